// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Writer-side companion to the CPU's read-only instruction memory. A byte
// stream arrives over a valid/ready handshake (UART receiver, debug port, ...).
// Every four bytes are packed little-endian into one 32-bit instruction word.
// Each finished word is written once into the instruction memory's write port.
// The first word goes to BASE_ADDR and later words follow at 4-byte steps.
// The CPU is held in reset for the whole load. done pulses when the program
// is in place.
//
// Ports
//   clk         system clock, all state changes on the rising edge
//   rst         synchronous, active-high reset
//   start       one-cycle load request, only looked at while idle
//   len_words   number of words to load, captured on an accepted start
//   byte_valid  stream byte present
//   byte_data   stream byte; lowest-addressed byte of a word comes first
//   byte_ready  loader takes a byte this cycle
//   wr_en       instruction-memory write strobe, one cycle per word
//   wr_addr     byte address of the word being written (4-aligned)
//   wr_data     assembled word, first byte in [7:0]
//   busy        load in progress
//   cpu_hold    keeps the CPU in reset while high
//   done        one-cycle pulse after the last word has been written
//   error       sticky flag: the last start request was rejected
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 8,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = 32'hBFC00000,
  parameter int                       DEPTH_WORDS   = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [10:0]              len_words,
  input  logic                     byte_valid,
  input  logic [DATA_WIDTH-1:0]    byte_data,
  output logic                     byte_ready,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [ADDRESS_WIDTH-1:0] wr_data,
  output logic                     busy,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     error
);

  localparam int LEN_W = 11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [LEN_W-1:0]         len_q;
  logic [LEN_W-1:0]         word_cnt_q;
  logic [1:0]               idx_q;
  logic [ADDRESS_WIDTH-1:0] word_buf_q;
  logic [ADDRESS_WIDTH-1:0] word_buf_next;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q;
  logic [ADDRESS_WIDTH-1:0] wr_data_q;
  logic                     error_q;

  logic start_ok;
  logic byte_xfer;
  logic last_word;

  // A load of zero words or of more words than the memory holds is refused.
  assign start_ok  = (len_words != '0) && (32'(len_words) <= 32'(DEPTH_WORDS));
  assign byte_xfer = byte_valid && byte_ready;
  assign last_word = (word_cnt_q == (len_q - LEN_W'(1)));

  // Insert the incoming byte at its lane of the word being assembled.
  always_comb begin
    word_buf_next = word_buf_q;
    word_buf_next[idx_q*DATA_WIDTH +: DATA_WIDTH] = byte_data;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment first keeps this block free of inferred
  // latches when no case branch changes state_d.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start && start_ok)            state_d = S_COLLECT;
      S_COLLECT: if (byte_xfer && idx_q == 2'd3)   state_d = S_WRITE;
      S_WRITE:   state_d = last_word ? S_DONE : S_COLLECT;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from state only. There is no combinational path from
  // start or byte_valid to any port.
  // ---------------------------------------------------------------------------
  always_comb begin
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    busy       = 1'b0;
    cpu_hold   = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_COLLECT: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        cpu_hold   = 1'b1;
      end
      S_WRITE: begin
        wr_en    = 1'b1;
        busy     = 1'b1;
        cpu_hold = 1'b1;
      end
      S_DONE: begin
        done     = 1'b1;
        busy     = 1'b1;
        cpu_hold = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: length, counters, word assembly, write port and error flag
  // ---------------------------------------------------------------------------
  // NOTE: the assembly buffer is a register, not a memory array, so it is
  // cleared on reset. A word cut off by rst cannot leak into a later write.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q      <= '0;
      word_cnt_q <= '0;
      idx_q      <= '0;
      word_buf_q <= '0;
      wr_addr_q  <= BASE_ADDR;
      wr_data_q  <= '0;
      error_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (start_ok) begin
              len_q      <= len_words;
              word_cnt_q <= '0;
              idx_q      <= '0;
              error_q    <= 1'b0;
            end else begin
              error_q    <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          if (byte_xfer) begin
            word_buf_q <= word_buf_next;
            idx_q      <= idx_q + 2'd1;  // wraps to 0 after the 4th byte
            // The write port is loaded on the same edge that takes the last
            // byte, so wr_en/wr_addr/wr_data all line up in the WRITE cycle.
            if (idx_q == 2'd3) begin
              wr_data_q <= word_buf_next;
              wr_addr_q <= BASE_ADDR + (ADDRESS_WIDTH'(word_cnt_q) << 2);
            end
          end
        end
        S_WRITE: begin
          if (!last_word) word_cnt_q <= word_cnt_q + LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  // wr_addr/wr_data hold their last value outside WRITE; qualify with wr_en.
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign error   = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. A reference model builds the expected
// write list from the byte stream with plain arithmetic. Word i goes to
// BASE + 4*i and is bytes[4i] | bytes[4i+1]<<8 | bytes[4i+2]<<16 | bytes[4i+3]<<24.
// A negedge monitor records every write and checks the handshake properties.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] len_words;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  bytes_q[$];
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  int          done_cnt  = 0;
  int          bytes_acc = 0;
  logic        prev_xfer = 1'b0;
  logic        prev_wr_en = 1'b0;

  imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len_words  (len_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        check("wr_ready_low", 32'(byte_ready), 32'd0);
        check("wr_after_4th_byte", 32'(prev_xfer), 32'd1);
        check("wr_full_word", 32'((obs_addr.size() + 1) * 4 <= bytes_acc), 32'd1);
        obs_addr.push_back(wr_addr);
        obs_data.push_back(wr_data);
      end
      if (done) begin
        check("done_after_last_wr", 32'(prev_wr_en), 32'd1);
        check("busy_at_done", 32'(busy), 32'd1);
        done_cnt++;
      end
      if (cpu_hold !== busy) check("hold_eq_busy", 32'(cpu_hold), 32'(busy));
    end
    prev_xfer  = byte_valid && byte_ready;
    prev_wr_en = wr_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_wr_en"},      32'(wr_en),      32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_cpu_hold"},   32'(cpu_hold),   32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_error"},      32'(error),      32'd0);
    check({tag, "_wr_addr"},    wr_addr,         BASE);
    check({tag, "_wr_data"},    wr_data,         32'd0);
  endtask

  task automatic do_start(input int len);
    start     = 1'b1;
    len_words = 11'(len);
    tick();
    start     = 1'b0;
  endtask

  // Feed n bytes from bytes_q. A byte counts as taken when valid and ready are
  // both high before the edge. Once valid is raised it is held until taken.
  task automatic stream(input int n, input int stall_pct, input int start_at);
    int i      = 0;
    int cycles = 0;
    bit hold_v = 1'b0;
    bit xfer;
    while (i < n && cycles < 20 * n + 100) begin
      if (!hold_v) byte_valid = ($urandom_range(0, 99) >= stall_pct);
      byte_data = bytes_q[i];
      if (i == start_at) begin
        start     = 1'b1;
        len_words = 11'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      xfer = byte_valid && byte_ready;
      tick();
      hold_v = byte_valid && !xfer;
      if (xfer) begin
        i++;
        bytes_acc++;
      end
      cycles++;
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    check("stream_bytes_taken", 32'(i), 32'(n));
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
    done_cnt  = 0;
    bytes_acc = 0;
  endtask

  // Complete load of len words, then compare against the reference model.
  task automatic run_load(input int len, input int stall_pct, input int start_at, input bit fixed);
    int k;
    int n;
    logic [31:0] exp_data;
    if (!fixed) begin
      bytes_q.delete();
      for (int b = 0; b < 4 * len; b++) bytes_q.push_back(8'($urandom_range(0, 255)));
    end
    clear_obs();
    do_start(len);
    check("busy_after_start", 32'(busy), 32'd1);
    check("hold_after_start", 32'(cpu_hold), 32'd1);
    check("error_after_start", 32'(error), 32'd0);
    stream(4 * len, stall_pct, start_at);
    k = 0;
    while (done_cnt == 0 && k < 20) begin
      tick();
      k++;
    end
    check("done_seen", 32'(done_cnt > 0), 32'd1);
    check("busy_after_done", 32'(busy), 32'd0);
    check("hold_after_done", 32'(cpu_hold), 32'd0);
    repeat (3) tick();
    check("done_count", 32'(done_cnt), 32'd1);
    check("write_count", 32'(obs_addr.size()), 32'(len));
    n = (obs_addr.size() < len) ? obs_addr.size() : len;
    for (int j = 0; j < n; j++) begin
      exp_data = 32'(bytes_q[4*j])            + (32'(bytes_q[4*j+1]) * 256) +
                 (32'(bytes_q[4*j+2]) * 65536) + (32'(bytes_q[4*j+3]) * 16777216);
      check("wr_addr", obs_addr[j], BASE + 32'(4 * j));
      check("wr_data", obs_data[j], exp_data);
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    len_words  = '0;
    byte_data  = '0;
    repeat (2) tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();

    // 1: single word 0x00000513
    bytes_q = '{8'h13, 8'h05, 8'h00, 8'h00};
    run_load(1, 0, -1, 1'b1);
    if (obs_data.size() > 0) check("t1_word", obs_data[0], 32'h00000513);

    // 2: three words back-to-back
    run_load(3, 0, -1, 1'b0);

    // 3: two words with random stalls
    run_load(2, 40, -1, 1'b0);

    // 4: rejected starts
    clear_obs();
    do_start(0);
    check("len0_error", 32'(error), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    check("len0_ready", 32'(byte_ready), 32'd0);
    repeat (2) tick();
    do_start(1025);
    check("len1025_error", 32'(error), 32'd1);
    check("len1025_busy", 32'(busy), 32'd0);
    check("len1025_ready", 32'(byte_ready), 32'd0);
    repeat (2) tick();
    check("rejected_no_wr", 32'(obs_addr.size()), 32'd0);
    run_load(1, 0, -1, 1'b0);

    // 5: reset in the middle of the second word
    bytes_q.delete();
    for (int b = 0; b < 8; b++) bytes_q.push_back(8'($urandom_range(0, 255)));
    clear_obs();
    do_start(2);
    stream(6, 0, -1);
    rst = 1'b1;
    tick();
    check_reset_vals("midrst");
    rst = 1'b0;
    repeat (3) tick();
    check("midrst_writes", 32'(obs_addr.size()), 32'd1);
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    run_load(1, 0, -1, 1'b0);

    // 6: full depth, with a start pulse in the middle of the load
    run_load(1024, 0, 1500, 1'b0);
    if (obs_addr.size() > 0) check("t6_last_addr", obs_addr[obs_addr.size()-1], 32'hBFC00FFC);
    check("t6_no_error", 32'(error), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart to the CPU's read-only instruction memory.
- Accepts a byte stream over a valid/ready handshake, e.g. from a UART receiver or debug port.
- Assembles the bytes into 32-bit little-endian instruction words and issues one write per word into the instruction memory's write port, starting at the boot base address 0xBFC00000.
- Holds the CPU in reset while loading and pulses done when the program is in place.

Parameters:
- ADDRESS_WIDTH, 32, width of wr_addr and wr_data.
- DATA_WIDTH, 8, width of one stream byte (byte addressing: 4 bytes per word).
- BASE_ADDR, 32'hBFC00000, byte address of the first word written.
- DEPTH_WORDS, 1024, capacity in words (covers 0xBFC00000–0xBFC00FFF).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a load; sampled only in IDLE.
- len_words  input  11  number of words to load; latched on the accepted start.
- byte_valid  input  1  stream byte present.
- byte_data  input  DATA_WIDTH  stream byte; the lowest-addressed byte of each word arrives first.
- byte_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  instruction-memory write strobe, one cycle per word.
- wr_addr  output  ADDRESS_WIDTH  byte address of the word being written (always 4-aligned).
- wr_data  output  ADDRESS_WIDTH  assembled word: first byte in [7:0], fourth byte in [31:24].
- busy  output  1  load in progress.
- cpu_hold  output  1  holds the CPU in reset while high.
- done  output  1  one-cycle pulse after the last word is written.
- error  output  1  sticky flag for a rejected start.

Behaviour:
- Reset values: state=IDLE. byte_ready, wr_en, busy, cpu_hold, done and error are 0. wr_addr=BASE_ADDR. wr_data=0. The word counter and byte index are 0.
- States: IDLE, COLLECT, WRITE, DONE. All outputs are registered or decoded from state only; there are no combinational paths from byte_valid or start to any output.
- IDLE:
  - start with 1 <= len_words <= DEPTH_WORDS: latch len, clear the word counter and byte index, clear error, go to COLLECT.
  - start with len_words==0 or len_words>DEPTH_WORDS: set error=1, stay in IDLE. error stays set until the next accepted start or rst.
- COLLECT:
  - byte_ready=1, busy=1, cpu_hold=1.
  - A byte transfers only on a cycle where byte_valid && byte_ready. The transferred byte goes to word_buf[8*idx+7 : 8*idx], then idx increments.
  - A transfer with idx==3 moves to WRITE. idx wraps to 0.
  - byte_valid low simply stalls: no timeout, state held indefinitely.
- WRITE:
  - byte_ready=0. wr_en=1 for exactly this one cycle.
  - wr_addr = BASE_ADDR + 4*word_cnt, wr_data = word_buf.
  - Next state is DONE if word_cnt == len-1, otherwise COLLECT with word_cnt incremented.
- DONE: done=1 for exactly one cycle. busy and cpu_hold fall on the following edge. Return to IDLE.
- Latency:
  - The 4th byte of a word is accepted on edge N; wr_en is high in the cycle after edge N.
  - Peak throughput is 4 bytes per 5 cycles.
  - The last write is followed by a done pulse one cycle later.
- start asserted while not in IDLE is ignored, including in DONE; it does not set error.
- wr_addr never exceeds BASE_ADDR + 4*(DEPTH_WORDS-1). The address computation is 32-bit unsigned, with no wrap inside the legal range.
- wr_data and wr_addr hold their last values outside WRITE. Consumers qualify them with wr_en only.
- rst mid-load, in any state: the next edge returns to IDLE with the reset values above.
  - Any partially assembled word is discarded.
  - No wr_en is produced for a word that has not completed.
  - cpu_hold drops to 0.
- Bytes presented while byte_ready=0 (IDLE, WRITE, DONE) are not consumed. The source holds them under normal valid/ready rules.

Test Plan:
1. Reset, then start with len_words=1 and stream 0x13,0x05,0x00,0x00 with byte_valid held high:
   - one wr_en pulse with wr_addr=0xBFC00000 and wr_data=0x00000513, one cycle after the 4th byte;
   - done pulses one cycle later;
   - busy and cpu_hold are high from start until after done.
2. len_words=3 with 12 bytes back-to-back:
   - three writes to 0xBFC00000, 0xBFC00004, 0xBFC00008;
   - byte_ready is low in each WRITE cycle;
   - the words match little-endian assembly of each 4-byte group;
   - exactly one done.
3. len_words=2 with byte_valid randomly deasserted between bytes:
   - same two words and addresses as the unstalled case;
   - no wr_en while fewer than 4 bytes of a word are held.
4. start with len_words=0, then with len_words=1025:
   - error=1, state stays IDLE, byte_ready=0, no wr_en;
   - a following start with len_words=1 clears error.
5. len_words=2: send 6 bytes, assert rst for one cycle, then release:
   - one wr_en only (the first word);
   - outputs return to reset values;
   - a new start with len_words=1 writes again at 0xBFC00000.
6. len_words=1024 with full stream:
   - last write at wr_addr=0xBFC00FFC;
   - 1024 wr_en pulses total;
   - start pulsed mid-load is ignored.
